// File: rtl/pc_pkg.sv
// Shared constants for the program counter sequencer: FSM encodings and address arithmetic.
package pc_pkg;

    localparam logic [2:0] PC_RST_WAIT = 3'd0;
    localparam logic [2:0] PC_RUN      = 3'd1;
    localparam logic [2:0] PC_STALLED  = 3'd2;
    localparam logic [2:0] PC_FLUSH    = 3'd3;
    localparam logic [2:0] PC_HALTED   = 3'd4;

    localparam logic [31:0] PC_INCR    = 32'd4;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_sequencer_program_counter.sv
// ProgramCounter: plain 32-bit register loaded every cycle, synchronous active-high reset.
module ProgramCounter #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Address,
    output logic [31:0] PC
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC <= RESET_VECTOR;
        end else begin
            PC <= Address;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: selects the next fetch address and tracks reset wait, stalls, flushes and halt.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned RESET_WAIT   = 2,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        Halt,
    output logic [31:0] PCOut,
    output logic [31:0] PCPlus4,
    output logic        FetchValid,
    output logic        FlushIFID,
    output logic        Halted,
    output logic [15:0] StallCount
);

    localparam logic [3:0] WAIT_LAST  = 4'(RESET_WAIT - 1);
    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [1:0]  flush_q, flush_d;
    logic        valid_q, valid_d;
    logic        flushout_q, flushout_d;
    logic        halted_q, halted_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] target;

    assign PCPlus4  = PCOut + PC_INCR;
    assign redirect = Jump | BranchTaken;
    assign target   = (Jump ? JumpTarget : BranchTarget) & ALIGN_MASK;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        flush_d     = flush_q;
        valid_d     = valid_q;
        flushout_d  = flushout_q;
        halted_d    = halted_q;
        stall_cnt_d = stall_cnt_q;
        next_pc     = PCOut;

        case (state_q)
            PC_RST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = PC_RUN;
                    valid_d = 1'b1;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            PC_RUN, PC_STALLED, PC_FLUSH: begin
                if (redirect) begin
                    next_pc    = target;
                    state_d    = PC_FLUSH;
                    flush_d    = FLUSH_LAST;
                    flushout_d = 1'b1;
                    valid_d    = 1'b1;
                end else if (Halt) begin
                    state_d    = PC_HALTED;
                    valid_d    = 1'b0;
                    halted_d   = 1'b1;
                    flushout_d = 1'b0;
                end else if (state_q == PC_FLUSH && flush_q != 2'd0) begin
                    // Mid-flush the pipeline is being refilled; Stall is only honoured at expiry.
                    next_pc = PCPlus4;
                    flush_d = flush_q - 2'd1;
                end else if (Stall) begin
                    state_d    = PC_STALLED;
                    flushout_d = 1'b0;
                    if (stall_cnt_q != 16'hFFFF) begin
                        stall_cnt_d = stall_cnt_q + 16'd1;
                    end
                end else begin
                    next_pc    = PCPlus4;
                    state_d    = PC_RUN;
                    flushout_d = 1'b0;
                end
            end
            default: begin
                // HALTED: only Reset leaves this state.
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= PC_RST_WAIT;
            wait_q      <= 4'd0;
            flush_q     <= 2'd0;
            valid_q     <= 1'b0;
            flushout_q  <= 1'b0;
            halted_q    <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            flush_q     <= flush_d;
            valid_q     <= valid_d;
            flushout_q  <= flushout_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    ProgramCounter #(
        .RESET_VECTOR(RESET_VECTOR)
    ) u_pc (
        .Clk    (Clk),
        .Reset  (Reset),
        .Address(next_pc),
        .PC     (PCOut)
    );

    assign FetchValid = valid_q;
    assign FlushIFID  = flushout_q;
    assign Halted     = halted_q;
    assign StallCount = stall_cnt_q;

endmodule
